// File: rtl/sap1_controller_pkg.sv
// sap1_controller_pkg
// Shared definitions for the SAP-1 control sequencer and the datapath blocks
// that consume its control word: opcode constants, control-word bit indices
// and masks, and the one-hot T-state encoding.
package sap1_controller_pkg;

  localparam int unsigned CTRL_W = 12;

  // Control-word bit indices (datapath blocks decode ctrl_o with these)
  localparam int unsigned CP_BIT = 11;
  localparam int unsigned EP_BIT = 10;
  localparam int unsigned LM_BIT = 9;
  localparam int unsigned CE_BIT = 8;
  localparam int unsigned LI_BIT = 7;
  localparam int unsigned EI_BIT = 6;
  localparam int unsigned LA_BIT = 5;
  localparam int unsigned EA_BIT = 4;
  localparam int unsigned SU_BIT = 3;
  localparam int unsigned EU_BIT = 2;
  localparam int unsigned LB_BIT = 1;
  localparam int unsigned LO_BIT = 0;

  function automatic logic [CTRL_W-1:0] cw_bit(input int unsigned idx);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  localparam logic [CTRL_W-1:0] CW_CP = cw_bit(CP_BIT);
  localparam logic [CTRL_W-1:0] CW_EP = cw_bit(EP_BIT);
  localparam logic [CTRL_W-1:0] CW_LM = cw_bit(LM_BIT);
  localparam logic [CTRL_W-1:0] CW_CE = cw_bit(CE_BIT);
  localparam logic [CTRL_W-1:0] CW_LI = cw_bit(LI_BIT);
  localparam logic [CTRL_W-1:0] CW_EI = cw_bit(EI_BIT);
  localparam logic [CTRL_W-1:0] CW_LA = cw_bit(LA_BIT);
  localparam logic [CTRL_W-1:0] CW_EA = cw_bit(EA_BIT);
  localparam logic [CTRL_W-1:0] CW_SU = cw_bit(SU_BIT);
  localparam logic [CTRL_W-1:0] CW_EU = cw_bit(EU_BIT);
  localparam logic [CTRL_W-1:0] CW_LB = cw_bit(LB_BIT);
  localparam logic [CTRL_W-1:0] CW_LO = cw_bit(LO_BIT);

  // Opcodes (IR upper nibble)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot ring-counter states, bit 0 is T1
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

endpackage

// File: rtl/sap1_controller_if.sv
// sap1_controller_if
// Sequencer <-> datapath signal group.
//   en_i      : advance enable (low = stall)
//   opcode_i  : IR upper nibble
//   ctrl_o    : 12-bit active-high control word
//   t_state_o : one-hot current T-state (bit 0 = T1)
//   halted_o  : high once HLT has executed
// master = datapath / stimulus side, slave = sequencer.
interface sap1_controller_if #(
  parameter int unsigned OPCODE_W = 4
);
  logic                en_i;
  logic [OPCODE_W-1:0] opcode_i;
  logic [11:0]         ctrl_o;
  logic [5:0]          t_state_o;
  logic                halted_o;

  modport master (
    output en_i, opcode_i,
    input  ctrl_o, t_state_o, halted_o
  );

  modport slave (
    input  en_i, opcode_i,
    output ctrl_o, t_state_o, halted_o
  );
endinterface

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter
// Six-state one-hot ring counter T1->T2->...->T6->T1.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, returns to T1
//   advance : step one state this edge
//   hold    : freeze the state (overrides advance, not reset)
//   t_state : one-hot current state
module sap1_ring_counter
  import sap1_controller_pkg::*;
#(
  parameter int unsigned T_STATES = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                advance,
  input  logic                hold,
  output logic [T_STATES-1:0] t_state
);

  t_state_e state, state_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= T1;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (advance && !hold) begin
      unique case (state)
        T1:      state_nxt = T2;
        T2:      state_nxt = T3;
        T3:      state_nxt = T4;
        T4:      state_nxt = T5;
        T5:      state_nxt = T6;
        T6:      state_nxt = T1;
        default: state_nxt = T1;
      endcase
    end
  end

  assign t_state = T_STATES'(state);

endmodule

// File: rtl/sap1_controller.sv
// sap1_controller
// SAP-1 control sequencer: ring counter, instruction decoder and halt latch.
//   clk_i : clock, rising edge (same edge as the datapath)
//   rst_i : synchronous active-high reset
//   bus   : sap1_controller_if.slave (en_i, opcode_i in; ctrl_o, t_state_o,
//           halted_o out)
// ctrl_o is purely combinational from state, opcode, enable, reset and halt.
module sap1_controller
  import sap1_controller_pkg::*;
#(
  parameter int unsigned T_STATES = 6,
  parameter int unsigned OPCODE_W = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  sap1_controller_if.slave   bus
);

  logic [T_STATES-1:0] t_state;
  t_state_e            state;
  logic                halted;
  logic                halt_now;
  logic [CTRL_W-1:0]   ctrl;

  localparam logic [OPCODE_W-1:0] LDA = OPCODE_W'(OP_LDA);
  localparam logic [OPCODE_W-1:0] ADD = OPCODE_W'(OP_ADD);
  localparam logic [OPCODE_W-1:0] SUB = OPCODE_W'(OP_SUB);
  localparam logic [OPCODE_W-1:0] OUT = OPCODE_W'(OP_OUT);
  localparam logic [OPCODE_W-1:0] HLT = OPCODE_W'(OP_HLT);

  assign state = t_state_e'(t_state[5:0]);

  // HLT retires on the enabled T4 edge; the counter must not leave T4 then.
  assign halt_now = bus.en_i && !halted && (state == T4) && (bus.opcode_i == HLT);

  sap1_ring_counter #(
    .T_STATES (T_STATES)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .advance (bus.en_i),
    .hold    (halted || halt_now),
    .t_state (t_state)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)         halted <= 1'b0;
    else if (halt_now) halted <= 1'b1;
  end

  always_comb begin
    ctrl = '0;
    if (!rst_i && bus.en_i && !halted) begin
      unique case (state)
        T1: ctrl = CW_EP | CW_LM;
        T2: ctrl = CW_CP;
        T3: ctrl = CW_CE | CW_LI;
        T4: begin
          case (bus.opcode_i)
            LDA, ADD, SUB: ctrl = CW_EI | CW_LM;
            OUT:           ctrl = CW_EA | CW_LO;
            default:       ctrl = '0;
          endcase
        end
        T5: begin
          case (bus.opcode_i)
            LDA:      ctrl = CW_CE | CW_LA;
            ADD, SUB: ctrl = CW_CE | CW_LB;
            default:  ctrl = '0;
          endcase
        end
        T6: begin
          case (bus.opcode_i)
            ADD:     ctrl = CW_EU | CW_LA;
            SUB:     ctrl = CW_SU | CW_EU | CW_LA;
            default: ctrl = '0;
          endcase
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.ctrl_o    = ctrl;
  assign bus.t_state_o = t_state[5:0];
  assign bus.halted_o  = halted;

endmodule

// File: tb/tb_sap1_controller.sv
module tb_sap1_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sap1_controller_if #(.OPCODE_W(4)) bus ();

  sap1_controller #(
    .T_STATES (6),
    .OPCODE_W (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  typedef struct {
    string       tag;
    logic [11:0] c;
    logic [5:0]  t;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string tag, input logic r, input logic e,
                      input logic [3:0] op, input logic [11:0] c,
                      input logic [5:0] t, input logic h);
    exp_t x;
    exp_t got;
    logic [4:0] drv;
    @(negedge clk);
    rst          = r;
    bus.en_i     = e;
    bus.opcode_i = op;
    x.tag = tag; x.c = c; x.t = t; x.h = h;
    sb.push_back(x);
    #1;
    got = sb.pop_front();
    checks++;
    assert (bus.ctrl_o === got.c) else begin
      errors++;
      $error("FAIL %s ctrl observed %03h expected %03h", got.tag, bus.ctrl_o, got.c);
    end
    checks++;
    assert (bus.t_state_o === got.t) else begin
      errors++;
      $error("FAIL %s t_state observed %06b expected %06b", got.tag, bus.t_state_o, got.t);
    end
    checks++;
    assert (bus.halted_o === got.h) else begin
      errors++;
      $error("FAIL %s halted observed %b expected %b", got.tag, bus.halted_o, got.h);
    end
    drv = {bus.ctrl_o[10], bus.ctrl_o[8], bus.ctrl_o[6], bus.ctrl_o[4], bus.ctrl_o[2]};
    checks++;
    assert ($countones(drv) <= 1) else begin
      errors++;
      $error("FAIL %s bus_drive observed %05b expected at most one high", got.tag, drv);
    end
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    step({tag, "_t1"}, 1'b0, 1'b1, op, 12'h600, S1, 1'b0);
    step({tag, "_t2"}, 1'b0, 1'b1, op, 12'h800, S2, 1'b0);
    step({tag, "_t3"}, 1'b0, 1'b1, op, 12'h180, S3, 1'b0);
  endtask

  task automatic exec(input string tag, input logic [3:0] op, input logic [11:0] c4,
                      input logic [11:0] c5, input logic [11:0] c6);
    step({tag, "_t4"}, 1'b0, 1'b1, op, c4, S4, 1'b0);
    step({tag, "_t5"}, 1'b0, 1'b1, op, c5, S5, 1'b0);
    step({tag, "_t6"}, 1'b0, 1'b1, op, c6, S6, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.en_i     = 1'b1;
    bus.opcode_i = 4'h0;

    step("reset0", 1'b1, 1'b1, 4'h0, 12'h000, S1, 1'b0);
    step("reset1", 1'b1, 1'b1, 4'h0, 12'h000, S1, 1'b0);

    // opcode during fetch is ignored, even HLT
    fetch("add", 4'hF);
    exec("add", 4'h1, 12'h240, 12'h102, 12'h024);

    fetch("lda", 4'h0);
    exec("lda", 4'h0, 12'h240, 12'h120, 12'h000);

    fetch("sub", 4'h2);
    exec("sub", 4'h2, 12'h240, 12'h102, 12'h02C);

    fetch("out", 4'hE);
    exec("out", 4'hE, 12'h011, 12'h000, 12'h000);

    fetch("nop", 4'h7);
    exec("nop", 4'h7, 12'h000, 12'h000, 12'h000);

    // stall in T5 of ADD
    fetch("stall", 4'h1);
    step("stall_t4", 1'b0, 1'b1, 4'h1, 12'h240, S4, 1'b0);
    for (int i = 0; i < 5; i++)
      step("stall_hold", 1'b0, 1'b0, 4'h1, 12'h000, S5, 1'b0);
    step("stall_resume", 1'b0, 1'b1, 4'h1, 12'h102, S5, 1'b0);
    step("stall_t6", 1'b0, 1'b1, 4'h1, 12'h024, S6, 1'b0);

    // reset in T5 of SUB
    fetch("rsub", 4'h2);
    step("rsub_t4", 1'b0, 1'b1, 4'h2, 12'h240, S4, 1'b0);
    step("rsub_t5_rst", 1'b1, 1'b1, 4'h2, 12'h000, S5, 1'b0);
    step("rsub_held", 1'b1, 1'b1, 4'h2, 12'h000, S1, 1'b0);
    step("rsub_release", 1'b0, 1'b1, 4'hF, 12'h600, S1, 1'b0);
    step("rsub_t2", 1'b0, 1'b1, 4'hF, 12'h800, S2, 1'b0);
    step("rsub_t3", 1'b0, 1'b1, 4'hF, 12'h180, S3, 1'b0);

    // reset beats HLT retiring in T4
    step("rhlt_t4_rst", 1'b1, 1'b1, 4'hF, 12'h000, S4, 1'b0);
    step("rhlt_after", 1'b0, 1'b1, 4'hF, 12'h600, S1, 1'b0);
    step("hlt_t2", 1'b0, 1'b1, 4'hF, 12'h800, S2, 1'b0);
    step("hlt_t3", 1'b0, 1'b1, 4'hF, 12'h180, S3, 1'b0);

    // HLT executes and freezes in T4
    step("hlt_t4", 1'b0, 1'b1, 4'hF, 12'h000, S4, 1'b0);
    for (int i = 0; i < 20; i++)
      step("halted", 1'b0, 1'b1, 4'h1, 12'h000, S4, 1'b1);
    step("halted_rst", 1'b1, 1'b1, 4'hF, 12'h000, S4, 1'b1);
    step("halt_cleared", 1'b0, 1'b1, 4'hF, 12'h600, S1, 1'b0);
    step("halt_cleared_t2", 1'b0, 1'b1, 4'hF, 12'h800, S2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
